score_digit_encoder: RTL and testbench
======================================

SCORE_DIGIT_ENCODER -- requirements
Module: score_digit_encoder

Interface
REQ-001 SHALL have parameter SCORE_W, default 10, binary score width; legal range 10 to 16.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Score  input  SCORE_W  unsigned binary score, sampled only when Start is accepted.
REQ-005 SHALL have port Start  input  1  conversion request, one-cycle pulse, accepted only when Busy is low.
REQ-006 SHALL have ports Digit2, Digit1, Digit0  output  6 each  character codes (hundreds, tens, ones) for the glyph renderer: 0-9 digits, 36 space, 63 '?'.
REQ-007 SHALL have port Busy  output  1  high while a conversion is in progress.
REQ-008 SHALL have port Done  output  1  one-cycle pulse marking Digit2..Digit0 updated.

Function
REQ-009 SHALL implement FSM states IDLE, SHIFT, FINISH.
REQ-010 SHALL, in IDLE with Start=1, latch Score, clear the 12-bit BCD accumulator, load shift counter = SCORE_W, and go to SHIFT.
REQ-011 SHALL, in SHIFT, per cycle add 3 to every BCD nibble >= 5, then shift {BCD, score} left 1, and decrement the counter.
REQ-012 SHALL go SHIFT->FINISH when the counter reaches 0 (exactly SCORE_W SHIFT cycles).
REQ-013 SHALL, in FINISH, register the digit codes and go to IDLE; Done=1 and Busy=0 from the next edge.
REQ-014 SHALL assert Busy from the edge after Start acceptance until the edge on which Done rises; latency Start->Done = SCORE_W+2 cycles (12 at default).
REQ-015 SHALL hold Digit2..Digit0 at previous values throughout a conversion; they change only on the Done edge.
REQ-016 SHALL ignore Start while Busy=1; Start in the Done cycle SHALL be accepted.
REQ-017 SHALL treat a latched Score > 999 as overflow: all three digits = 63, same latency and Done pulse.
REQ-018 SHALL output Score=0 as Digit0=0 (ones digit never blanked).
REQ-019 SHALL use an accumulator wide enough for SCORE_W=16 without loss; only the low 3 nibbles are output, overflow detected by comparison at latch.

Reset
REQ-020 SHALL, on reset low, immediately and asynchronously force FSM=IDLE, Busy=0, Done=0, counter=0, Digit2..Digit0 to the value for score 0 (per REQ-022).
REQ-021 SHALL, on reset mid-conversion, abort without Done pulse; first Start after release SHALL be accepted.

Configuration
REQ-022 SHALL honour macro LEADING_BLANK_EN: defined -> leading zero hundreds/tens digits output as 36 (tens blanked only if hundreds blank), reset value 36/36/0; undefined -> zeros output as 0, reset value 0/0/0.

Verification
REQ-023 Reset low, then release -> Busy=0, Done=0, digits 36/36/0 (macro on) or 0/0/0 (macro off).
REQ-024 Start with Score=427 -> Busy high 11 cycles, Done pulse 12 cycles after Start, digits 4/2/7.
REQ-025 Score=5 -> 36/36/5 with LEADING_BLANK_EN, 0/0/5 without; Score=40 -> 36/4/0 or 0/4/0.
REQ-026 Score=1000 and Score=999 -> 63/63/63 and 9/9/9 respectively, both with 12-cycle latency.
REQ-027 Start(Score=427), Start again at cycle 3 with Score=9 -> second ignored, result 4/2/7; Start with Score=9 on the Done cycle -> accepted, result 36/36/9 after 12 more cycles.
REQ-028 Reset asserted at cycle 6 of a conversion -> outputs take reset values immediately, no Done; next Start(Score=12) -> 36/1/2.

Source files
------------

// File: rtl/score_digit_encoder.sv
// score_digit_encoder
//
// Converts an unsigned binary score into three 6-bit character codes for the glyph
// renderer (hundreds, tens, ones). The codes are 0-9 for digits, 36 for a space and
// 63 for '?'. The conversion is a sequential double-dabble: one bit per cycle, so
// Start->Done latency is SCORE_W+2 cycles. Scores above 999 show as "???".
//
// Build option:
//   LEADING_BLANK_EN  defined   -> a leading zero hundreds digit is shown as a space; the
//                                  tens digit is blanked only when it is zero and the
//                                  hundreds digit is already blank. Reset shows 36/36/0.
//                     undefined -> leading zeros are shown as 0. Reset shows 0/0/0.
//
// Ports:
//   clk            sole clock, rising edge
//   reset          asynchronous, active-low reset
//   Score          binary score, sampled only when Start is accepted
//   Start          conversion request pulse, accepted only while Busy is low
//   Digit2..0      character codes (hundreds, tens, ones); change only on the Done edge
//   Busy           high while a conversion is in progress
//   Done           one-cycle pulse: Digit2..0 have just been updated

module score_digit_encoder #(
  parameter int unsigned SCORE_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SCORE_W-1:0] Score,
  input  logic               Start,
  output logic [5:0]         Digit2,
  output logic [5:0]         Digit1,
  output logic [5:0]         Digit0,
  output logic               Busy,
  output logic               Done
);

  // Five BCD nibbles hold 65535, the largest 16-bit score, so no intermediate
  // value is lost even though only the low three nibbles are displayed.
  localparam int unsigned BcdW = 20;
  localparam int unsigned CntW = $clog2(SCORE_W + 1);

  localparam logic [5:0] CodeSpace = 6'd36;
  localparam logic [5:0] CodeOvf   = 6'd63;
  localparam logic [5:0] CodeZero  = 6'd0;

`ifdef LEADING_BLANK_EN
  localparam logic [5:0] RstDigit2 = CodeSpace;
  localparam logic [5:0] RstDigit1 = CodeSpace;
`else
  localparam logic [5:0] RstDigit2 = CodeZero;
  localparam logic [5:0] RstDigit1 = CodeZero;
`endif
  localparam logic [5:0] RstDigit0 = CodeZero;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StFinish
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [SCORE_W-1:0]  sh_q, sh_d;
  logic [BcdW-1:0]     bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic [5:0]          dig2_q, dig2_d;
  logic [5:0]          dig1_q, dig1_d;
  logic [5:0]          dig0_q, dig0_d;
  logic                done_q, done_d;

  logic [BcdW-1:0]     bcd_adj;
  logic [5:0]          code2, code1, code0;

  // Double-dabble correction: any nibble >= 5 gets +3 so that the following
  // left shift carries correctly into the next decimal digit.
  function automatic logic [BcdW-1:0] dabble_adjust(input logic [BcdW-1:0] bcd);
    logic [BcdW-1:0] res;
    res = bcd;
    for (int i = 0; i < int'(BcdW / 4); i++) begin
      if (res[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = res[4*i +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

  assign bcd_adj = dabble_adjust(bcd_q);

  // Character codes for the finished accumulator.
  always_comb begin
    code0 = {2'b00, bcd_q[3:0]};
`ifdef LEADING_BLANK_EN
    if (bcd_q[11:8] == 4'd0) begin
      code2 = CodeSpace;
      code1 = (bcd_q[7:4] == 4'd0) ? CodeSpace : {2'b00, bcd_q[7:4]};
    end else begin
      code2 = {2'b00, bcd_q[11:8]};
      code1 = {2'b00, bcd_q[7:4]};
    end
`else
    code2 = {2'b00, bcd_q[11:8]};
    code1 = {2'b00, bcd_q[7:4]};
`endif
    if (ovf_q) begin
      code2 = CodeOvf;
      code1 = CodeOvf;
      code0 = CodeOvf;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    dig2_d  = dig2_q;
    dig1_d  = dig1_q;
    dig0_d  = dig0_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          sh_d    = Score;
          bcd_d   = '0;
          cnt_d   = CntW'(SCORE_W);
          // Overflow is decided once, on the latched value.
          ovf_d   = (Score > SCORE_W'(999));
          state_d = StShift;
        end
      end
      StShift: begin
        {bcd_d, sh_d} = {bcd_adj, sh_q} << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        dig2_d  = code2;
        dig1_d  = code1;
        dig0_d  = code0;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      dig2_q  <= RstDigit2;
      dig1_q  <= RstDigit1;
      dig0_q  <= RstDigit0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      dig2_q  <= dig2_d;
      dig1_q  <= dig1_d;
      dig0_q  <= dig0_d;
      done_q  <= done_d;
    end
  end

  // Busy covers the SHIFT and FINISH cycles; it drops on the same edge Done rises.
  assign Busy   = (state_q != StIdle);
  assign Done   = done_q;
  assign Digit2 = dig2_q;
  assign Digit1 = dig1_q;
  assign Digit0 = dig0_q;

endmodule

// File: tb/tb_score_digit_encoder.sv
module tb_score_digit_encoder;

  logic       clk;
  logic       reset;
  logic [9:0] Score;
  logic       Start;
  logic [5:0] Digit2, Digit1, Digit0;
  logic       Busy, Done;

  int total = 0;
  int bad   = 0;

`ifdef LEADING_BLANK_EN
  localparam bit Blank = 1'b1;
`else
  localparam bit Blank = 1'b0;
`endif
  localparam logic [5:0] RstD2 = Blank ? 6'd36 : 6'd0;
  localparam logic [5:0] RstD1 = Blank ? 6'd36 : 6'd0;

  score_digit_encoder dut (
    .clk    (clk),
    .reset  (reset),
    .Score  (Score),
    .Start  (Start),
    .Digit2 (Digit2),
    .Digit1 (Digit1),
    .Digit0 (Digit0),
    .Busy   (Busy),
    .Done   (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Plain digits p*, and the hundreds/tens codes with leading blanking b2/b1.
  typedef struct {
    logic [9:0] sc;
    logic [5:0] p2, p1, p0;
    logic [5:0] b2, b1;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge while Start is high; leaves the bench at cycle 1.
  task automatic kick(input logic [9:0] sc);
    Score = sc;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  // Starts at cycle 1 of a conversion; returns at the negedge where Done is high.
  // inject_at > 0 raises Start (Score=9) during that cycle to probe the busy guard.
  task automatic wait_done(input int inject_at, output int done_at, output int busy_cnt,
                           output bit held);
    logic [5:0] p2, p1, p0;
    p2 = Digit2; p1 = Digit1; p0 = Digit0;
    done_at  = -1;
    busy_cnt = 0;
    held     = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (Done) begin
        done_at = k;
        break;
      end
      if (Busy) busy_cnt++;
      if (Digit2 !== p2 || Digit1 !== p1 || Digit0 !== p0) held = 1'b0;
      if (k == inject_at) begin
        Score = 10'd9;
        Start = 1'b1;
      end else if (k == inject_at + 1) begin
        Start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string tag, input int done_at, input int busy_cnt,
                              input bit held, input logic [5:0] e2, input logic [5:0] e1,
                              input logic [5:0] e0);
    check({tag, " latency"}, done_at, 12);
    check({tag, " busy_cycles"}, busy_cnt, 11);
    check({tag, " busy_at_done"}, Busy, 0);
    check({tag, " digits_held"}, held, 1);
    check({tag, " digit2"}, Digit2, e2);
    check({tag, " digit1"}, Digit1, e1);
    check({tag, " digit0"}, Digit0, e0);
  endtask

  initial begin
    int  d, b, cnt_done, cnt_busy;
    bit  h;
    logic [5:0] e2, e1;

    vecs[0]  = '{10'd427,  6'd4,  6'd2,  6'd7,  6'd4,  6'd2};
    vecs[1]  = '{10'd5,    6'd0,  6'd0,  6'd5,  6'd36, 6'd36};
    vecs[2]  = '{10'd40,   6'd0,  6'd4,  6'd0,  6'd36, 6'd4};
    vecs[3]  = '{10'd1000, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63};
    vecs[4]  = '{10'd999,  6'd9,  6'd9,  6'd9,  6'd9,  6'd9};
    vecs[5]  = '{10'd0,    6'd0,  6'd0,  6'd0,  6'd36, 6'd36};
    vecs[6]  = '{10'd105,  6'd1,  6'd0,  6'd5,  6'd1,  6'd0};
    vecs[7]  = '{10'd1023, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63};
    vecs[8]  = '{10'd900,  6'd9,  6'd0,  6'd0,  6'd9,  6'd0};
    vecs[9]  = '{10'd7,    6'd0,  6'd0,  6'd7,  6'd36, 6'd36};
    vecs[10] = '{10'd12,   6'd0,  6'd1,  6'd2,  6'd36, 6'd1};

    // Reset
    reset = 1'b1;
    Start = 1'b0;
    Score = '0;
    #3 reset = 1'b0;
    #1;
    check("reset_low busy", Busy, 0);
    check("reset_low done", Done, 0);
    check("reset_low digit2", Digit2, RstD2);
    check("reset_low digit1", Digit1, RstD1);
    check("reset_low digit0", Digit0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset busy", Busy, 0);
    check("post_reset done", Done, 0);
    check("post_reset digit2", Digit2, RstD2);
    check("post_reset digit1", Digit1, RstD1);
    check("post_reset digit0", Digit0, 0);

    // Table-driven conversions
    foreach (vecs[i]) begin
      e2 = Blank ? vecs[i].b2 : vecs[i].p2;
      e1 = Blank ? vecs[i].b1 : vecs[i].p1;
      @(negedge clk);
      kick(vecs[i].sc);
      wait_done(-1, d, b, h);
      check_result($sformatf("score%0d", vecs[i].sc), d, b, h, e2, e1, vecs[i].p0);
      @(negedge clk);
      check($sformatf("score%0d done_pulse_width", vecs[i].sc), Done, 0);
    end

    // Start while busy is ignored; Start in the Done cycle is accepted
    @(negedge clk);
    kick(10'd427);
    wait_done(3, d, b, h);
    check_result("ignore_busy_start", d, b, h, 6'd4, 6'd2, 6'd7);
    kick(10'd9);
    wait_done(-1, d, b, h);
    check_result("start_on_done", d, b, h, Blank ? 6'd36 : 6'd0, Blank ? 6'd36 : 6'd0,
                 6'd9);

    // Reset in the middle of a conversion
    @(negedge clk);
    kick(10'd427);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_reset busy", Busy, 0);
    check("mid_reset done", Done, 0);
    check("mid_reset digit2", Digit2, RstD2);
    check("mid_reset digit1", Digit1, RstD1);
    check("mid_reset digit0", Digit0, 0);
    @(negedge clk);
    reset = 1'b1;
    cnt_done = 0;
    cnt_busy = 0;
    repeat (15) begin
      @(negedge clk);
      if (Done) cnt_done++;
      if (Busy) cnt_busy++;
    end
    check("mid_reset no_done", cnt_done, 0);
    check("mid_reset no_busy", cnt_busy, 0);
    kick(10'd12);
    wait_done(-1, d, b, h);
    check_result("after_reset score12", d, b, h, Blank ? 6'd36 : 6'd0, 6'd1, 6'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
